qspi_mem_target: RTL and testbench

// Synthesizable QSPI memory target: the device end of the exotiny QSPI ROM/RAM interface.

---
 rtl/qspi_mem_target_pkg.sv | 24 ++
 rtl/qspi_mem_target_if.sv | 33 +++
 rtl/qspi_mem_target_sync_edge.sv | 50 +++++
 rtl/qspi_mem_target.sv | 194 +++++++++++++++++++
 tb/tb_qspi_mem_target.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_mem_target_pkg.sv
// Shared types and constants for the QSPI memory target: FSM state encoding,
// supported command codes and address framing length.
package qspi_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } qspi_state_e;

  localparam logic [7:0] CMD_QREAD    = 8'hEB;
  localparam logic [7:0] CMD_QWRITE   = 8'h38;
  localparam int         ADDR_NIBBLES = 6;

  // A write command on a read-only instance is handled like any unknown code.
  function automatic logic cmd_supported(input logic [7:0] cmd, input bit read_only);
    return (cmd == CMD_QREAD) || ((cmd == CMD_QWRITE) && !read_only);
  endfunction

endpackage

// File: rtl/qspi_mem_target_if.sv
// Pin-side and memory-side signals of one QSPI memory target. The slave modport
// is the target's view; the master modport is the initiator plus backing memory.
interface qspi_mem_target_if #(
  parameter int MEM_AW = 16
);

  logic              cs_in;
  logic              sck_i;
  logic [3:0]        sd_i;
  logic [3:0]        sd_o;
  logic [3:0]        sd_oen_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic              mem_re_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_we_o;
  logic [7:0]        mem_wdata_o;
  logic              busy_o;
  logic              err_o;

  // Memory port handshake: mem_re_o is a 1-clk strobe and mem_rdata_i must hold
  // the addressed byte exactly one clk later; mem_we_o is a 1-clk strobe with
  // mem_addr_o/mem_wdata_o valid in the same clk. There is no back-pressure.
  modport slave (
    input  cs_in, sck_i, sd_i, mem_rdata_i,
    output sd_o, sd_oen_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, busy_o, err_o
  );

  modport master (
    output cs_in, sck_i, sd_i, mem_rdata_i,
    input  sd_o, sd_oen_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, busy_o, err_o
  );

endinterface

// File: rtl/qspi_mem_target_sync_edge.sv
// Two-flop synchronizers for the asynchronous SPI pins plus edge pulses for
// sck and cs, all aligned to the synchronized data lines.
module qspi_sync_edge (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_in,
  input  logic       sck_i,
  input  logic [3:0] sd_i,
  output logic       cs_low,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic [3:0] sd
);

  logic [1:0] cs_ff;
  logic [1:0] sck_ff;
  logic [3:0] sd_ff1;
  logic [3:0] sd_ff2;
  logic       cs_d;
  logic       sck_d;

  // cs resets to deasserted so no spurious transaction starts out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_ff  <= 2'b11;
      sck_ff <= 2'b00;
      sd_ff1 <= 4'h0;
      sd_ff2 <= 4'h0;
      cs_d   <= 1'b1;
      sck_d  <= 1'b0;
    end else begin
      cs_ff  <= {cs_ff[0], cs_in};
      sck_ff <= {sck_ff[0], sck_i};
      sd_ff1 <= sd_i;
      sd_ff2 <= sd_ff1;
      cs_d   <= cs_ff[1];
      sck_d  <= sck_ff[1];
    end
  end

  assign cs_low   = ~cs_ff[1];
  assign cs_fall  = ~cs_ff[1] & cs_d;
  assign cs_rise  = cs_ff[1] & ~cs_d;
  assign sck_rise = sck_ff[1] & ~sck_d;
  assign sck_fall = ~sck_ff[1] & sck_d;
  assign sd       = sd_ff2;

endmodule

// File: rtl/qspi_mem_target.sv
// QSPI memory target: decodes quad read (0xEB) and quad write (0x38) frames from
// oversampled SPI pins and serves them from a byte-wide memory port.
module qspi_mem_target
  import qspi_target_pkg::*;
#(
  parameter int MEM_AW    = 16,
  parameter int DUMMY_CYC = 6,
  parameter bit READ_ONLY = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  qspi_mem_target_if.slave bus,
  output qspi_state_e      dbg_state
);

  if (DUMMY_CYC < 1) begin : g_dummy_check
    $error("qspi_mem_target: DUMMY_CYC must be at least 1");
  end

  qspi_state_e       state, state_n;
  logic              cs_low, cs_fall, cs_rise, sck_rise, sck_fall;
  logic [3:0]        sd;
  logic [7:0]        cnt;
  logic [6:0]        cmd_sr;
  logic [7:0]        cmd_next;
  logic              is_write;
  logic [MEM_AW-1:0] addr_q;
  logic [7:0]        rbuf;
  logic [3:0]        lo_nib;
  logic              nib_hi;
  logic [3:0]        w_hi;
  logic              w_half;
  logic              rd_valid;
  logic [3:0]        sd_o_q;
  logic [3:0]        oen_q;
  logic              re_q, we_q;
  logic [7:0]        wdata_q;
  logic              err_q;
  logic              last_cmd, last_addr, last_dummy;

  qspi_sync_edge u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cs_in    (bus.cs_in),
    .sck_i    (bus.sck_i),
    .sd_i     (bus.sd_i),
    .cs_low   (cs_low),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .sd       (sd)
  );

  assign cmd_next   = {cmd_sr, sd[0]};
  assign last_cmd   = (cnt == 8'd7);
  assign last_addr  = (cnt == 8'(ADDR_NIBBLES - 1));
  assign last_dummy = (cnt == 8'(DUMMY_CYC - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_rise) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (cs_fall) state_n = ST_CMD;
        ST_CMD:   if (sck_rise && last_cmd)
                    state_n = cmd_supported(cmd_next, READ_ONLY) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:  if (sck_rise && last_addr) state_n = is_write ? ST_WDATA : ST_DUMMY;
        ST_DUMMY: if (sck_rise && last_dummy) state_n = ST_RDATA;
        default:  state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= 8'd0;
      cmd_sr   <= 7'd0;
      is_write <= 1'b0;
      addr_q   <= '0;
      rbuf     <= 8'h00;
      lo_nib   <= 4'h0;
      nib_hi   <= 1'b0;
      w_hi     <= 4'h0;
      w_half   <= 1'b0;
      rd_valid <= 1'b0;
      sd_o_q   <= 4'h0;
      oen_q    <= 4'h0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      rd_valid <= re_q;
      if (rd_valid) rbuf <= mem_rdata_capture(bus.mem_rdata_i);
      if (cs_rise) begin
        // rd_valid cleared here drops any response still in flight.
        cnt      <= 8'd0;
        nib_hi   <= 1'b0;
        w_half   <= 1'b0;
        rd_valid <= 1'b0;
        oen_q    <= 4'h0;
        sd_o_q   <= 4'h0;
      end else begin
        case (state)
          ST_IDLE: if (cs_fall) begin
            cnt    <= 8'd0;
            w_half <= 1'b0;
          end
          ST_CMD: if (sck_rise) begin
            cmd_sr <= cmd_next[6:0];
            if (last_cmd) begin
              cnt      <= 8'd0;
              addr_q   <= '0;
              is_write <= (cmd_next == CMD_QWRITE);
              if (!cmd_supported(cmd_next, READ_ONLY)) err_q <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_ADDR: if (sck_rise) begin
            // Shifting through a MEM_AW-wide register keeps only the low address bits.
            addr_q <= MEM_AW'({addr_q, sd});
            if (last_addr) begin
              cnt  <= 8'd0;
              re_q <= !is_write;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_DUMMY: if (sck_rise) begin
            if (last_dummy) begin
              cnt    <= 8'd0;
              nib_hi <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_RDATA: if (sck_fall) begin
            oen_q <= 4'hF;
            if (nib_hi) begin
              // Start of a byte: prefetch the next one while this byte shifts out.
              sd_o_q <= rbuf[7:4];
              lo_nib <= rbuf[3:0];
              addr_q <= addr_q + MEM_AW'(1);
              re_q   <= 1'b1;
              nib_hi <= 1'b0;
            end else begin
              sd_o_q <= lo_nib;
              nib_hi <= 1'b1;
            end
          end
          ST_WDATA: begin
            if (we_q) addr_q <= addr_q + MEM_AW'(1);
            if (sck_rise) begin
              if (w_half) begin
                we_q    <= 1'b1;
                wdata_q <= {w_hi, sd};
                w_half  <= 1'b0;
              end else begin
                w_hi   <= sd;
                w_half <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] mem_rdata_capture(input logic [7:0] d);
    return d;
  endfunction

  assign bus.sd_o        = sd_o_q;
  assign bus.sd_oen_o    = oen_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_re_o    = re_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.busy_o      = cs_low;
  assign bus.err_o       = err_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_qspi_mem_target.sv
// Directed bench for qspi_mem_target: a read-write instance (A) and a read-only
// instance (B), both MEM_AW=8, sharing sck/sd with separate chip selects.
module tb_qspi_mem_target;
  import qspi_target_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_a, cs_b, sck;
  logic [3:0]  sd_drv;
  logic [7:0]  rdata_a, rdata_b;
  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  wr_addr_a [$];
  logic [7:0]  wr_data_a [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  stress_data [256];
  int          we_b_cnt, collide, oen_b_seen;
  bit          sel_b, stress;
  int          errors, checks;
  qspi_state_e state_a, state_b;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  qspi_mem_target_if #(.MEM_AW(8)) bus_a ();
  qspi_mem_target_if #(.MEM_AW(8)) bus_b ();

  assign bus_a.cs_in       = cs_a;
  assign bus_a.sck_i       = sck;
  assign bus_a.sd_i        = sd_drv;
  assign bus_a.mem_rdata_i = rdata_a;
  assign bus_b.cs_in       = cs_b;
  assign bus_b.sck_i       = sck;
  assign bus_b.sd_i        = sd_drv;
  assign bus_b.mem_rdata_i = rdata_b;

  qspi_mem_target #(.MEM_AW(8), .DUMMY_CYC(6), .READ_ONLY(1'b0)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (bus_a), .dbg_state (state_a)
  );

  qspi_mem_target #(.MEM_AW(8), .DUMMY_CYC(6), .READ_ONLY(1'b1)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (bus_b), .dbg_state (state_b)
  );

  // Backing memories (1-clk read latency) and bus monitors.
  always @(posedge clk) begin
    if (bus_a.mem_re_o) rdata_a <= mem_a[bus_a.mem_addr_o];
    if (bus_a.mem_we_o) begin
      mem_a[bus_a.mem_addr_o] = bus_a.mem_wdata_o;
      wr_addr_a.push_back(bus_a.mem_addr_o);
      wr_data_a.push_back(bus_a.mem_wdata_o);
    end
    if (bus_b.mem_re_o) rdata_b <= mem_b[bus_b.mem_addr_o];
    if (bus_b.mem_we_o) we_b_cnt = we_b_cnt + 1;
    if (bus_b.sd_oen_o != 4'h0) oen_b_seen = 1;
    if ((bus_a.mem_re_o && bus_a.mem_we_o) || (bus_b.mem_re_o && bus_b.mem_we_o))
      collide = collide + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sck period: low phase with sd set up, rise, high phase, sample sd_o, fall.
  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q);
    int lo, hi;
    lo = stress ? int'($urandom_range(7, 4)) : 4;
    hi = stress ? int'($urandom_range(7, 4)) : 4;
    sd_drv = d;
    wait_clk(lo);
    sck = 1'b1;
    wait_clk(hi);
    q = sel_b ? bus_b.sd_o : bus_a.sd_o;
    sck = 1'b0;
  endtask

  task automatic open_txn(input bit use_b);
    sel_b = use_b;
    if (use_b) cs_b = 1'b0;
    else       cs_a = 1'b0;
    wait_clk(4);
  endtask

  task automatic close_txn();
    sd_drv = 4'h0;
    wait_clk(2);
    cs_a = 1'b1;
    cs_b = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, c[i]}, q);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] q;
    for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4], q);
  endtask

  task automatic send_dummy();
    logic [3:0] q;
    repeat (6) sck_cycle(4'h0, q);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic [3:0] h, l;
    sck_cycle(4'h0, h);
    sck_cycle(4'h0, l);
    b = {h, l};
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic [3:0] q;
    sck_cycle(b[7:4], q);
    sck_cycle(b[3:0], q);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    wait_clk(3);
    checks++;
    if ({bus_a.sd_o, bus_a.sd_oen_o, bus_a.mem_addr_o, bus_a.mem_re_o, bus_a.mem_we_o,
         bus_a.mem_wdata_o, bus_a.busy_o, bus_a.err_o} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs_a: got oen=%h addr=%h re=%b we=%b busy=%b err=%b want all 0",
               bus_a.sd_oen_o, bus_a.mem_addr_o, bus_a.mem_re_o, bus_a.mem_we_o, bus_a.busy_o, bus_a.err_o);
    end
    checks++;
    if ({bus_b.sd_o, bus_b.sd_oen_o, bus_b.mem_addr_o, bus_b.mem_re_o, bus_b.mem_we_o,
         bus_b.mem_wdata_o, bus_b.busy_o, bus_b.err_o} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs_b: got oen=%h addr=%h busy=%b err=%b want all 0",
               bus_b.sd_oen_o, bus_b.mem_addr_o, bus_b.busy_o, bus_b.err_o);
    end
    rst = 1'b0;
    wait_clk(3);
    checks++;
    if (state_a !== ST_IDLE || state_b !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got a=%0d b=%0d want %0d", state_a, state_b, ST_IDLE);
    end
  endtask

  task automatic test_quad_read();
    logic [3:0] exp_nib [8];
    logic [3:0] q;
    exp_nib = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h0, 4'h1, 4'hF, 4'hF};
    open_txn(1'b0);
    checks++;
    if (bus_a.busy_o !== 1'b1) begin
      errors++; $display("FAIL read_busy: got %b want 1", bus_a.busy_o);
    end
    send_cmd(CMD_QREAD);
    send_addr(24'h000010);
    send_dummy();
    for (int i = 0; i < 8; i++) begin
      sck_cycle(4'h0, q);
      checks++;
      if (q !== exp_nib[i]) begin
        errors++; $display("FAIL read_nibble[%0d]: got %h want %h", i, q, exp_nib[i]);
      end
    end
    checks++;
    if (bus_a.sd_oen_o !== 4'hF) begin
      errors++; $display("FAIL read_oen: got %h want f", bus_a.sd_oen_o);
    end
    close_txn();
    checks++;
    if (bus_a.sd_oen_o !== 4'h0 || state_a !== ST_IDLE || bus_a.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL read_release: got oen=%h state=%0d busy=%b want 0/%0d/0",
               bus_a.sd_oen_o, state_a, bus_a.busy_o, ST_IDLE);
    end
  endtask

  task automatic test_quad_write_wrap();
    logic [7:0] exp_addr [4];
    logic [7:0] exp_data [4];
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_addr_a.delete(); wr_data_a.delete();
    open_txn(1'b0);
    send_cmd(CMD_QWRITE);
    send_addr(24'h0000FE);
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    close_txn();
    checks++;
    if (wr_addr_a.size() != 4) begin
      errors++; $display("FAIL write_count: got %0d want 4", wr_addr_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_a[i] !== exp_addr[i] || wr_data_a[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL write[%0d]: got %h@%h want %h@%h", i, wr_data_a[i], wr_addr_a[i],
                   exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_read_only();
    logic [7:0] b;
    we_b_cnt = 0; oen_b_seen = 0;
    open_txn(1'b1);
    send_cmd(CMD_QWRITE);
    send_addr(24'h000010);
    write_byte(8'h99); write_byte(8'h77);
    checks++;
    if (state_b !== ST_IGNORE) begin
      errors++; $display("FAIL ro_state: got %0d want %0d", state_b, ST_IGNORE);
    end
    close_txn();
    checks++;
    if (we_b_cnt != 0 || bus_b.err_o !== 1'b1 || oen_b_seen != 0) begin
      errors++;
      $display("FAIL ro_write_blocked: got we=%0d err=%b oen_seen=%0d want 0/1/0",
               we_b_cnt, bus_b.err_o, oen_b_seen);
    end
    open_txn(1'b1);
    send_cmd(CMD_QREAD);
    send_addr(24'h000010);
    send_dummy();
    read_byte(b);
    checks++;
    if (b !== 8'h5A) begin errors++; $display("FAIL ro_read0: got %h want 5a", b); end
    read_byte(b);
    checks++;
    if (b !== 8'hC3) begin errors++; $display("FAIL ro_read1: got %h want c3", b); end
    close_txn();
    checks++;
    if (bus_b.err_o !== 1'b1) begin errors++; $display("FAIL ro_err_sticky: got %b want 1", bus_b.err_o); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] b;
    open_txn(1'b0);
    send_cmd(8'h9F);
    send_addr(24'h000000);
    checks++;
    if (state_a !== ST_IGNORE || bus_a.err_o !== 1'b1 || bus_a.sd_oen_o !== 4'h0) begin
      errors++;
      $display("FAIL bad_cmd: got state=%0d err=%b oen=%h want %0d/1/0",
               state_a, bus_a.err_o, bus_a.sd_oen_o, ST_IGNORE);
    end
    close_txn();
    checks++;
    if (bus_a.err_o !== 1'b1 || state_a !== ST_IDLE) begin
      errors++; $display("FAIL bad_cmd_sticky: got err=%b state=%0d want 1/%0d", bus_a.err_o, state_a, ST_IDLE);
    end
    open_txn(1'b0);
    send_cmd(CMD_QREAD);
    send_addr(24'h000000);
    send_dummy();
    read_byte(b);
    checks++;
    if (b !== 8'h33) begin errors++; $display("FAIL after_bad_read0: got %h want 33", b); end
    read_byte(b);
    checks++;
    if (b !== 8'h44) begin errors++; $display("FAIL after_bad_read1: got %h want 44", b); end
    close_txn();
  endtask

  task automatic test_odd_nibbles();
    logic [3:0] q;
    wr_addr_a.delete(); wr_data_a.delete();
    open_txn(1'b0);
    send_cmd(CMD_QWRITE);
    send_addr(24'h000020);
    sck_cycle(4'h5, q); sck_cycle(4'h6, q); sck_cycle(4'h7, q);
    close_txn();
    checks++;
    if (wr_addr_a.size() != 1) begin
      errors++; $display("FAIL odd_write_count: got %0d want 1", wr_addr_a.size());
    end else begin
      checks++;
      if (wr_addr_a[0] !== 8'h20 || wr_data_a[0] !== 8'h56) begin
        errors++; $display("FAIL odd_write: got %h@%h want 56@20", wr_data_a[0], wr_addr_a[0]);
      end
    end
  endtask

  task automatic test_cs_release_read();
    logic [3:0] q;
    open_txn(1'b0);
    send_cmd(CMD_QREAD);
    send_addr(24'h000012);
    send_dummy();
    sck_cycle(4'h0, q);
    checks++;
    if (q !== 4'h0) begin errors++; $display("FAIL rel_nib0: got %h want 0", q); end
    sck_cycle(4'h0, q);
    checks++;
    if (q !== 4'h1) begin errors++; $display("FAIL rel_nib1: got %h want 1", q); end
    sck_cycle(4'h0, q);
    checks++;
    if (q !== 4'hF || bus_a.sd_oen_o !== 4'hF) begin
      errors++; $display("FAIL rel_nib2: got %h oen=%h want f/f", q, bus_a.sd_oen_o);
    end
    wait_clk(1);
    cs_a = 1'b1;
    wait_clk(4);
    checks++;
    if (bus_a.sd_oen_o !== 4'h0) begin
      errors++; $display("FAIL rel_oen: got %h want 0 within 4 clk", bus_a.sd_oen_o);
    end
    wait_clk(8);
    checks++;
    if (state_a !== ST_IDLE) begin errors++; $display("FAIL rel_state: got %0d want %0d", state_a, ST_IDLE); end
  endtask

  task automatic test_stress();
    logic [7:0] b, e;
    stress = 1'b1;
    wr_addr_a.delete(); wr_data_a.delete(); exp_q.delete();
    open_txn(1'b0);
    send_cmd(CMD_QWRITE);
    send_addr(24'h000000);
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(255, 0));
      stress_data[i] = b;
      exp_q.push_back(b);
      write_byte(b);
    end
    close_txn();
    checks++;
    if (wr_addr_a.size() != 256) begin
      errors++; $display("FAIL stress_write_count: got %0d want 256", wr_addr_a.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (wr_addr_a[i] !== 8'(i) || wr_data_a[i] !== stress_data[i]) begin
          errors++;
          $display("FAIL stress_write[%0d]: got %h@%h want %h@%h", i, wr_data_a[i], wr_addr_a[i],
                   stress_data[i], 8'(i));
        end
      end
    end
    open_txn(1'b0);
    send_cmd(CMD_QREAD);
    send_addr(24'h000000);
    send_dummy();
    for (int i = 0; i < 256; i++) begin
      read_byte(b);
      e = exp_q.pop_front();
      checks++;
      if (b !== e) begin errors++; $display("FAIL stress_read[%0d]: got %h want %h", i, b, e); end
    end
    close_txn();
    stress = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] b;
    open_txn(1'b0);
    send_cmd(CMD_QREAD);
    send_addr(24'h000010);
    send_dummy();
    read_byte(b);
    sck = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_a.sd_o, bus_a.sd_oen_o, bus_a.mem_addr_o, bus_a.mem_re_o, bus_a.mem_we_o,
         bus_a.mem_wdata_o, bus_a.busy_o, bus_a.err_o} !== 28'h0 || state_a !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_read_reset: got oen=%h addr=%h busy=%b err=%b state=%0d want all 0/IDLE",
               bus_a.sd_oen_o, bus_a.mem_addr_o, bus_a.busy_o, bus_a.err_o, state_a);
    end
    wait_clk(2);
    sck = 1'b0;
    cs_a = 1'b1;
    rst = 1'b0;
    wait_clk(8);
    open_txn(1'b0);
    send_cmd(CMD_QREAD);
    send_addr(24'h000010);
    send_dummy();
    read_byte(b);
    checks++;
    if (b !== stress_data[16]) begin
      errors++; $display("FAIL post_reset_read: got %h want %h", b, stress_data[16]);
    end
    close_txn();
  endtask

  task automatic test_no_collision();
    checks++;
    if (collide != 0) begin errors++; $display("FAIL re_we_overlap: got %0d want 0", collide); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; cs_a = 1'b1; cs_b = 1'b1; sck = 1'b0; sd_drv = 4'h0;
    sel_b = 1'b0; stress = 1'b0; errors = 0; checks = 0;
    we_b_cnt = 0; collide = 0; oen_b_seen = 0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00; mem_b[i] = 8'h00; stress_data[i] = 8'h00;
    end
    mem_a[16] = 8'hA5; mem_a[17] = 8'h3C; mem_a[18] = 8'h01; mem_a[19] = 8'hFF;
    mem_b[16] = 8'h5A; mem_b[17] = 8'hC3; mem_b[18] = 8'h10; mem_b[19] = 8'hFF;
    test_reset();
    test_quad_read();
    test_cs_release_read();
    test_quad_write_wrap();
    test_read_only();
    test_bad_cmd();
    test_odd_nibbles();
    test_stress();
    test_reset_mid_read();
    test_no_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
